lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store initiator between the core's execute stage and the word-organised data memory unit. Accepts one RV32I load or store per request and decodes funct3 into byte, halfword or word accesses. Sub-word stores use read-modify-write cycles on the memory port. Loaded bytes and halfwords are extracted, then sign- or zero-extended. The core stalls while `req_ready` is low.

## Interface
- `WIDTH`, 32, data and address width; the only supported value is 32.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present; sampled only when `req_ready`=1.
- `req_ready`  out  1  high in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `req_addr`  in  WIDTH  byte address.
- `req_wdata`  in  WIDTH  store data; the low byte or halfword is used for SB/SH.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; misaligned access or illegal funct3.
- `load_data`  out  WIDTH  extended load result; valid with `done`; holds its value until the next `done`.
- `mem_read_en`  out  1  memory read strobe.
- `mem_write_en`  out  1  memory write strobe.
- `mem_addr`  out  WIDTH  word index = {2'b00, addr[31:2]}.
- `mem_wdata`  out  WIDTH  full word to write.
- `mem_rdata`  in  WIDTH  combinational read data from memory, valid in the same cycle as `mem_read_en`.

## Operation
- **Request capture:** on acceptance, `addr`, `funct3`, `store` and `wdata` are latched into internal registers. Later changes on the `req_*` inputs are ignored.
- **States:** IDLE, RD, WR, RESP.
  - IDLE + accept, legal load: go to RD.
  - IDLE + accept, SB/SH: go to RD.
  - IDLE + accept, SW: go to WR.
  - IDLE + accept, illegal or misaligned request: go to RESP with `err`=1. No memory strobe is issued.
  - RD, load: the selected field of `mem_rdata` is extended into `load_data`. Go to RESP.
  - RD, SB/SH: `mem_rdata` is latched as the merge word. Go to WR.
  - WR: `mem_write_en`=1. Go to RESP.
  - RESP: `done`=1 for exactly one cycle. Go to IDLE.
- **Strobe decode:** `mem_read_en`=1 only in RD; `mem_write_en`=1 only in WR. `mem_addr` is driven from the latched address in RD and WR; it is 0 in IDLE and RESP.
- **Byte and halfword lane selection:** byte lane = addr[1:0]; halfword lane = addr[1].
  - LB, LH: sign-extend the selected field.
  - LBU, LHU: zero-extend the selected field.
- **Merge for sub-word stores:** only the selected byte or halfword lane of the merge word is replaced by `wdata[7:0]` or `wdata[15:0]`. The other lanes are written back unchanged.
- **Illegal funct3 values:**
  - loads: 3, 6, 7;
  - stores: any value above 2.
  - An illegal request sets `err`=1 and `load_data`=0, and performs no memory access.
- **Misalignment:**
  - LH, LHU, SH: addr[0]=1;
  - LW, SW: addr[1:0]≠0;
  - handling depends on the configuration below.
- **Reset:** on the reset edge the state goes to IDLE, and `done`, `err` and `load_data` go to 0. If `rst` is asserted during a WR cycle, that write may land at the reset edge; no further memory access follows it. An in-flight request is dropped and no `done` is produced for it.

## Timing
- Acceptance edge = E0; one cycle is one clock period.
  - Word or sub-word load: RD in cycle E0+1, `done` in cycle E0+2.
  - SW: WR in cycle E0+1, `done` in cycle E0+2.
  - SB/SH: RD in cycle E0+1, WR in cycle E0+2, `done` in cycle E0+3.
  - Error: `done`=1 and `err`=1 in cycle E0+1.
- `req_ready`=0 from E0 until the edge that ends RESP. Back-to-back requests are therefore accepted every 3 cycles (4 cycles for SB/SH); no request is taken in the same cycle as `done`.
- The memory read is combinational: `mem_rdata` is sampled at the edge that ends the RD cycle.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
  - **Defined:** a misaligned access completes as an error: `err`=1, `load_data`=0, no memory strobes.
  - **Not defined:** misaligned addresses are aligned down to the access size and the access proceeds normally. `err` is then raised only for illegal funct3.

## Test plan
- **LW:** memory word 5 = 0xDEADBEEF; LW with addr 0x14 → one RD cycle with `mem_addr`=5; `done` at E0+2 with `load_data`=0xDEADBEEF and `err`=0.
- **LB / LBU:** same word; LB at 0x17 → `load_data`=0xFFFFFFDE; LBU at 0x17 → 0x000000DE; LHU at 0x14 → 0x0000BEEF.
- **SB:** word 2 = 0x11223344; SB at 0x09 with wdata 0xAA → RD then WR of 0x1122AA44 to word 2; `done` at E0+3.
- **SW:** SW at 0x20 with wdata 0xCAFEF00D → single WR of 0xCAFEF00D to word 8; no RD cycle.
- **Misaligned LW:** LW at 0x02.
  - With `LSU_MISALIGN_TRAP_EN` → `done` at E0+1 with `err`=1 and no strobes.
  - Without it → word 0 is read with `err`=0.
- **Reset mid-operation:** assert `rst` during the RD cycle of an SH → next cycle is IDLE with `req_ready`=1, no WR cycle, and all outputs 0.

Source files
------------

// File: rtl/lsu_if.sv
// Bundled request, completion and memory-port signals of the load/store unit.
// The slave side is the LSU; the master side is the core plus the data memory.
interface lsu_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] load_data;
    logic             mem_read_en;
    logic             mem_write_en;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, done, err, load_data,
        output mem_read_en, mem_write_en, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, done, err, load_data,
        input  mem_read_en, mem_write_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store initiator on a word-organised memory with read-modify-write sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses complete as errors instead of aligning down.
module lsu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] addr_r;
    logic [2:0]       funct3_r;
    logic             store_r;
    logic [WIDTH-1:0] word_r;
    logic             done_r;
    logic             err_r;
    logic [WIDTH-1:0] load_data_r;

    logic             capture_s;
    logic             err_set_s;
    logic             ld_we_s;
    logic [WIDTH-1:0] ld_val_s;
    logic             merge_we_s;
    logic             req_bad_s;

    function automatic logic funct3_illegal(input logic store, input logic [2:0] f3);
        logic bad;
        if (store) begin
            bad = (f3 > 3'd2);
        end else begin
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        return bad;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'd1:    mis = a[0];
            2'd2:    mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
`endif

    // Byte lane comes from addr[1:0], halfword lane from addr[1]; addr[0] of a
    // halfword never shifts, which is what makes the non-trapping align-down free.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] res;
        byte_sh = rdata >> {a, 3'b000};
        half_sh = rdata >> {a[1], 4'b0000};
        case (f3)
            3'd0:    res = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'd1:    res = {{16{half_sh[15]}}, half_sh[15:0]};
            3'd2:    res = rdata;
            3'd4:    res = {24'd0, byte_sh[7:0]};
            3'd5:    res = {16'd0, half_sh[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            3'd0: begin
                mask = 32'h0000_00FF << {a, 3'b000};
                data = {4{wd[7:0]}};
            end
            3'd1: begin
                mask = 32'h0000_FFFF << {a[1], 4'b0000};
                data = {2{wd[15:0]}};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wd;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    // Request legality decided from the live request inputs at acceptance.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad_s = funct3_illegal(bus.req_store, bus.req_funct3)
                  | addr_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
        req_bad_s = funct3_illegal(bus.req_store, bus.req_funct3);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        err_set_s    = 1'b0;
        ld_we_s      = 1'b0;
        ld_val_s     = 32'd0;
        merge_we_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    capture_s = 1'b1;
                    if (req_bad_s) begin
                        state_next_s = ST_RESP;
                        err_set_s    = 1'b1;
                        ld_we_s      = 1'b1;
                    end else if (bus.req_store && (bus.req_funct3 == 3'd2)) begin
                        state_next_s = ST_WR;
                    end else begin
                        state_next_s = ST_RD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (store_r) begin
                    merge_we_s   = 1'b1;
                    state_next_s = ST_WR;
                end else begin
                    ld_we_s      = 1'b1;
                    ld_val_s     = extend_load(funct3_r, addr_r[1:0], bus.mem_rdata);
                    state_next_s = ST_RESP;
                end
            end
            ST_WR:   state_next_s = ST_RESP;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request capture, merge word and registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r      <= 32'd0;
            funct3_r    <= 3'd0;
            store_r     <= 1'b0;
            word_r      <= 32'd0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            load_data_r <= 32'd0;
        end else begin
            done_r <= (state_next_s == ST_RESP);
            err_r  <= err_set_s;
            if (capture_s) begin
                addr_r   <= bus.req_addr;
                funct3_r <= bus.req_funct3;
                store_r  <= bus.req_store;
                word_r   <= bus.req_wdata;
            end else if (merge_we_s) begin
                word_r <= merge_store(funct3_r, addr_r[1:0], bus.mem_rdata, word_r);
            end
            if (ld_we_s) begin
                load_data_r <= ld_val_s;
            end
        end
    end

    assign bus.req_ready    = (state_r == ST_IDLE);
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.load_data    = load_data_r;
    assign bus.mem_read_en  = (state_r == ST_RD);
    assign bus.mem_write_en = (state_r == ST_WR);
    assign bus.mem_addr     = ((state_r == ST_RD) || (state_r == ST_WR))
                              ? {2'b00, addr_r[31:2]} : 32'd0;
    assign bus.mem_wdata    = (state_r == ST_WR) ? word_r : 32'd0;
endmodule
